// File: rtl/beat_scheduler_if.sv
// Bundle of the scheduler's control, chart-configuration and lane-broadcast signals.
// Latency: none (wires only).
// Backpressure: none; every signal is a pulse or level with no handshake stall.
// Ports: master = game controller / chart loader side, slave = beat_scheduler.
//   tick/start/pause/restart_req/miss : one-cycle request pulses into the scheduler
//   cfg_we/cfg_addr/cfg_data/cfg_ack  : chart write strobe and one-cycle acknowledge
//   state/beat_cnt/miss_cnt/game_over : game status
//   spawn/stop_or_endgame/restart     : broadcast to every lane
interface beat_scheduler_if #(
    parameter int LANES = 4
);
    logic             tick;
    logic             start;
    logic             pause;
    logic             restart_req;
    logic             miss;
    logic             cfg_we;
    logic [6:0]       cfg_addr;
    logic [LANES-1:0] cfg_data;
    logic             cfg_ack;
    logic [1:0]       state;
    logic [6:0]       beat_cnt;
    logic [LANES-1:0] spawn;
    logic             stop_or_endgame;
    logic             restart;
    logic [3:0]       miss_cnt;
    logic             game_over;

    modport master (
        output tick, start, pause, restart_req, miss,
        output cfg_we, cfg_addr, cfg_data,
        input  cfg_ack, state, beat_cnt, spawn, stop_or_endgame, restart,
        input  miss_cnt, game_over
    );

    modport slave (
        input  tick, start, pause, restart_req, miss,
        input  cfg_we, cfg_addr, cfg_data,
        output cfg_ack, state, beat_cnt, spawn, stop_or_endgame, restart,
        output miss_cnt, game_over
    );
endinterface

// File: rtl/beat_scheduler.sv
// Game sequencer: idle/play/pause/end FSM, tick-to-beat divider, chart table and lane spawn pulses.
// Latency: every output is registered; a request pulse is reflected one clock later.
// Backpressure: none; requests are one-cycle pulses resolved by a fixed priority each cycle.
// Ports: clk, rst_n (async active-low) plus bus (beat_scheduler_if.slave):
//   inputs  tick, start, pause, restart_req, miss, cfg_we, cfg_addr, cfg_data
//   outputs cfg_ack, state, beat_cnt, spawn, stop_or_endgame, restart, miss_cnt, game_over
module beat_scheduler #(
    parameter int LANES          = 4,
    parameter int TICKS_PER_BEAT = 10,
    parameter int END_BEAT       = 92,
    parameter int MAX_MISS       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    beat_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_END   = 2'd3
    } state_t;

    localparam int               TW         = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TW-1:0]    TICK_LAST  = TW'(TICKS_PER_BEAT - 1);
    localparam logic [6:0]       BEAT_END   = 7'(END_BEAT);
    localparam logic [6:0]       BEAT_LAST  = 7'(END_BEAT - 1);
    localparam logic [3:0]       MISS_LIMIT = 4'(MAX_MISS);

    state_t           state_q, state_n;
    logic [6:0]       beat_q, beat_n;
    logic [TW-1:0]    tick_q, tick_n;
    logic [3:0]       miss_q, miss_n;
    logic             go_q, go_n;
    logic [LANES-1:0] spawn_q, spawn_n;
    logic             restart_q, restart_n;
    logic             ack_q, ack_n;
    logic             stop_q;

    logic [LANES-1:0] chart_q [128];
    logic             chart_we;
    logic [6:0]       beat_inc;
    logic [3:0]       miss_inc;
    logic             beat_done;

    assign beat_inc  = beat_q + 7'd1;
    assign miss_inc  = (miss_q == 4'hF) ? 4'hF : miss_q + 4'd1;
    assign beat_done = bus.tick && (tick_q == TICK_LAST);
    // Chart writes only land while idle, so the table is stable for a whole game.
    assign chart_we  = bus.cfg_we && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) begin
                chart_q[i] <= '0;
            end
        end else if (chart_we) begin
            chart_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            tick_q    <= '0;
            miss_q    <= '0;
            go_q      <= 1'b0;
            spawn_q   <= '0;
            restart_q <= 1'b0;
            ack_q     <= 1'b0;
            stop_q    <= 1'b1;
        end else begin
            state_q   <= state_n;
            beat_q    <= beat_n;
            tick_q    <= tick_n;
            miss_q    <= miss_n;
            go_q      <= go_n;
            spawn_q   <= spawn_n;
            restart_q <= restart_n;
            ack_q     <= ack_n;
            // Registered from the next state so the freeze line tracks state with no decode glitch.
            stop_q    <= (state_n != ST_PLAY);
        end
    end

    always_comb begin
        state_n   = state_q;
        beat_n    = beat_q;
        tick_n    = tick_q;
        miss_n    = miss_q;
        go_n      = go_q;
        spawn_n   = '0;
        restart_n = 1'b0;
        ack_n     = chart_we;

        if (bus.restart_req) begin
            state_n   = ST_IDLE;
            beat_n    = '0;
            tick_n    = '0;
            miss_n    = '0;
            go_n      = 1'b0;
            restart_n = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_n = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (bus.miss) begin
                        miss_n = miss_inc;
                    end
                    if (bus.miss && (miss_inc >= MISS_LIMIT)) begin
                        // Game lost: any coincident tick is discarded.
                        state_n = ST_END;
                        go_n    = 1'b1;
                    end else if (beat_done && (beat_q == BEAT_LAST)) begin
                        // Final beat outranks pause so the last spawn is never lost.
                        tick_n  = '0;
                        beat_n  = BEAT_END;
                        spawn_n = chart_q[BEAT_END];
                        state_n = ST_END;
                    end else if (bus.pause) begin
                        state_n = ST_PAUSE;
                    end else if (bus.tick && (beat_q < BEAT_END)) begin
                        if (beat_done) begin
                            tick_n  = '0;
                            beat_n  = beat_inc;
                            spawn_n = chart_q[beat_inc];
                        end else begin
                            tick_n = tick_q + TW'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.pause) begin
                        state_n = ST_PLAY;
                    end
                end
                ST_END: begin
                    state_n = ST_END;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.state           = state_q;
    assign bus.beat_cnt        = beat_q;
    assign bus.miss_cnt        = miss_q;
    assign bus.game_over       = go_q;
    assign bus.spawn           = spawn_q;
    assign bus.restart         = restart_q;
    assign bus.cfg_ack         = ack_q;
    assign bus.stop_or_endgame = stop_q;

endmodule
